csel_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake.
- Successor to the fixed 32-bit combinational carry-select adder.
- Splits a WIDTH-bit operation into NSTAGES equal chunks, one chunk per pipeline stage. The carry is registered between stages.
- Adds a subtract mode, signed-overflow and zero flags, and backpressure.
- Sits between the operand-issue logic and the result-writeback buffers.

---
 rtl/csel_pipe_adder.sv | 155 +++++++++++++++
 tb/tb_csel_pipe_adder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csel_pipe_adder.sv
// csel_pipe_adder: pipelined carry-select adder/subtractor. Each stage resolves one CHUNK-bit
// slice and passes its carry forward, with a valid/ready handshake and registered result/flags.
module csel_pipe_adder #(
  parameter int WIDTH   = 32,
  parameter int NSTAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / NSTAGES;

  if (((WIDTH % NSTAGES) != 0) || (CHUNK < 2)) begin : g_param_check
    $error("csel_pipe_adder: WIDTH must be a multiple of NSTAGES and CHUNK must be >= 2");
  end

  logic [NSTAGES-1:0] valid_r;
  logic [NSTAGES-1:0] carry_r;
  logic [WIDTH-1:0]   a_r     [NSTAGES];
  logic [WIDTH-1:0]   b_r     [NSTAGES];
  logic [WIDTH-1:0]   sum_r   [NSTAGES];
  logic               ovf_r;
  logic               zero_r;

  logic [NSTAGES-1:0] load_s;
  logic               down_ready_s;
  logic [NSTAGES-1:0] stage_in_valid_s;
  logic [NSTAGES-1:0] stage_cin_s;
  logic [NSTAGES-1:0] nxt_carry_s;
  logic [WIDTH-1:0]   opa_s     [NSTAGES];
  logic [WIDTH-1:0]   opb_s     [NSTAGES];
  logic [WIDTH-1:0]   res_in_s  [NSTAGES];
  logic [WIDTH-1:0]   nxt_sum_s [NSTAGES];
  logic [WIDTH-1:0]   beff_s;
  logic               cin_eff_s;
  logic               ovf_s;
  logic               zero_s;

  // Subtraction is A + ~B + 1, so cin is overridden in that mode.
  always_comb begin
    if (op_sub) begin
      beff_s    = ~b;
      cin_eff_s = 1'b1;
    end else begin
      beff_s    = b;
      cin_eff_s = cin;
    end
  end

  // Ready ripples back from the consumer: a stage can load when empty or when its occupant moves on.
  always_comb begin
    load_s       = {NSTAGES{1'b0}};
    down_ready_s = out_ready;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      load_s[i]    = !valid_r[i] || down_ready_s;
      down_ready_s = load_s[i];
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic [CHUNK:0]   sum0_s;
    logic [CHUNK:0]   sum1_s;
    logic [CHUNK:0]   sel_s;
    logic [WIDTH-1:0] res_s;

    if (k == 0) begin : g_head
      assign opa_s[k]            = a;
      assign opb_s[k]            = beff_s;
      assign stage_cin_s[k]      = cin_eff_s;
      assign res_in_s[k]         = {WIDTH{1'b0}};
      assign stage_in_valid_s[k] = in_valid;
    end else begin : g_body
      assign opa_s[k]            = a_r[k-1];
      assign opb_s[k]            = b_r[k-1];
      assign stage_cin_s[k]      = carry_r[k-1];
      assign res_in_s[k]         = sum_r[k-1];
      assign stage_in_valid_s[k] = valid_r[k-1];
    end

    // Both carry hypotheses are built in parallel; the incoming carry only steers the mux.
    always_comb begin
      sum0_s = {1'b0, opa_s[k][k*CHUNK +: CHUNK]} + {1'b0, opb_s[k][k*CHUNK +: CHUNK]};
      sum1_s = {1'b0, opa_s[k][k*CHUNK +: CHUNK]} + {1'b0, opb_s[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, 1'b1};
      if (stage_cin_s[k]) begin
        sel_s = sum1_s;
      end else begin
        sel_s = sum0_s;
      end
      res_s                    = res_in_s[k];
      res_s[k*CHUNK +: CHUNK]  = sel_s[CHUNK-1:0];
    end

    assign nxt_sum_s[k]   = res_s;
    assign nxt_carry_s[k] = sel_s[CHUNK];
  end

  // Flags use the operand signs carried down the pipe and the fully assembled result.
  always_comb begin
    ovf_s  = (opa_s[NSTAGES-1][WIDTH-1] == opb_s[NSTAGES-1][WIDTH-1])
          && (nxt_sum_s[NSTAGES-1][WIDTH-1] != opa_s[NSTAGES-1][WIDTH-1]);
    zero_s = (nxt_sum_s[NSTAGES-1] == {WIDTH{1'b0}});
  end

  // Stage registers; data is captured only when a valid op moves in, so an idle output holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {NSTAGES{1'b0}};
      carry_r <= {NSTAGES{1'b0}};
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      for (int i = 0; i < NSTAGES; i++) begin
        a_r[i]   <= {WIDTH{1'b0}};
        b_r[i]   <= {WIDTH{1'b0}};
        sum_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NSTAGES; i++) begin
        if (load_s[i]) begin
          valid_r[i] <= stage_in_valid_s[i];
          if (stage_in_valid_s[i]) begin
            a_r[i]     <= opa_s[i];
            b_r[i]     <= opb_s[i];
            sum_r[i]   <= nxt_sum_s[i];
            carry_r[i] <= nxt_carry_s[i];
          end
        end
      end
      if (load_s[NSTAGES-1] && stage_in_valid_s[NSTAGES-1]) begin
        ovf_r  <= ovf_s;
        zero_r <= zero_s;
      end
    end
  end

  assign in_ready  = load_s[0];
  assign out_valid = valid_r[NSTAGES-1];
  assign sum       = sum_r[NSTAGES-1];
  assign cout      = carry_r[NSTAGES-1];
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Randomized and directed bench for csel_pipe_adder: a 32/4 main instance with handshake
// scenarios plus 16/2, 64/8 and 8/1 instances fed carry-chain corner operands.
module tb_csel_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          n_ret = 0;
  int          sw_acc = 0;
  int          sw_ret = 0;
  bit          exact_lat;

  logic        sw_valid, sw_cin, sw_sub;
  logic [63:0] sw_a, sw_b;

  typedef struct packed { logic [66:0] r; int c; logic ex; } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csel_pipe_adder #(.WIDTH(32), .NSTAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values; returns {zero, ovf, cout, sum}.
  function automatic logic [66:0] ref_op(input int w, input logic [63:0] x, input logic [63:0] y,
                                         input logic ci, input logic sub);
    logic signed [71:0] ux, uy, sx, sy, ur, sr, lim, cie;
    logic [63:0] mask, s;
    logic co, ov;
    mask = {64{1'b1}} >> (64 - w);
    ux   = {8'd0, x & mask};
    uy   = {8'd0, y & mask};
    cie  = $signed({71'd0, ci});
    lim  = 72'sd1 <<< (w - 1);
    sx   = x[w-1] ? ux - (lim <<< 1) : ux;
    sy   = y[w-1] ? uy - (lim <<< 1) : uy;
    if (sub) begin
      ur = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end else begin
      ur = ux + uy + cie;
      sr = sx + sy + cie;
      co = ur[w];
    end
    ov = (sr >= lim) || (sr < -lim);
    s  = ur[63:0] & mask;
    return {(s == 64'd0), ov, co, s};
  endfunction

  // Main scoreboard: front entry is compared whenever a result is presented.
  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (out_valid) begin
        if (mq.size() == 0) begin
          check_val("spurious_out", out_valid, 1'b0);
        end else begin
          check_val("sum", sum, mq[0].r[31:0]);
          check_val("cout", cout, mq[0].r[64]);
          check_val("ovf", ovf, mq[0].r[65]);
          check_val("zero", zero, mq[0].r[66]);
          if (out_ready) begin
            if (mq[0].ex) check_val("latency", cyc - mq[0].c, 4);
            void'(mq.pop_front());
            n_ret++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e.r  = ref_op(32, {32'd0, a}, {32'd0, b}, cin, op_sub);
        e.c  = cyc;
        e.ex = exact_lat;
        mq.push_back(e);
        n_acc++;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 0) ? 16 : ((g == 1) ? 64 : 8);
    localparam int N = (g == 0) ? 2  : ((g == 1) ? 8  : 1);
    logic         ir, ov, co, of, ze;
    logic [W-1:0] su;
    logic [66:0]  q[$];
    int           qc[$];
    logic [66:0]  e;
    int           c;

    csel_pipe_adder #(.WIDTH(W), .NSTAGES(N)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir), .a(sw_a[W-1:0]),
      .b(sw_b[W-1:0]), .cin(sw_cin), .op_sub(sw_sub), .out_valid(ov), .out_ready(1'b1),
      .sum(su), .cout(co), .ovf(of), .zero(ze));

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        qc.delete();
      end else begin
        if (ov) begin
          if (q.size() == 0) begin
            check_val("sweep_spurious", ov, 1'b0);
          end else begin
            e = q.pop_front();
            c = qc.pop_front();
            check_val($sformatf("sweep%0d_sum", W), su, e[W-1:0]);
            check_val($sformatf("sweep%0d_cout", W), co, e[64]);
            check_val($sformatf("sweep%0d_ovf", W), of, e[65]);
            check_val($sformatf("sweep%0d_zero", W), ze, e[66]);
            check_val($sformatf("sweep%0d_latency", W), cyc - c, N);
            sw_ret++;
          end
        end
        if (sw_valid) begin
          check_val("sweep_ready", ir, 1'b1);
          if (ir) begin
            q.push_back(ref_op(W, sw_a, sw_b, sw_cin, sw_sub));
            qc.push_back(cyc);
            sw_acc++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    a      = $urandom;
    b      = $urandom;
    cin    = 1'($urandom_range(0, 1));
    op_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && mq.size() != 0; i++) step();
    check_val("drain_empty", mq.size(), 0);
  endtask

  task automatic directed(input logic [31:0] a_i, input logic [31:0] b_i, input logic c_i,
                          input logic s_i, input logic [31:0] esum, input logic ecout,
                          input logic eovf, input logic ezero);
    int n;
    a = a_i; b = b_i; cin = c_i; op_sub = s_i; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_val("dir_latency", n, 4);
    check_val("dir_sum", sum, esum);
    check_val("dir_cout", cout, ecout);
    check_val("dir_ovf", ovf, eovf);
    check_val("dir_zero", zero, ezero);
    step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] corners [8];
    int acc;
    corners = '{64'h0, {64{1'b1}}, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA,
                64'h1, 64'h8080_8080_8080_8080, 64'h7F7F_7F7F_7F7F_7F7F, 64'h8000_0000_0000_0000};
    rst_n = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; op_sub = 1'b0;
    out_ready = 1'b1; exact_lat = 1'b1;
    sw_valid = 1'b0; sw_a = 64'd0; sw_b = 64'd0; sw_cin = 1'b0; sw_sub = 1'b0;

    #3;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_sum", sum, 32'd0);
    check_val("rst_flags", {cout, ovf, zero}, 3'b000);
    #9 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("idle_out_valid", out_valid, 1'b0);
      check_val("idle_in_ready", in_ready, 1'b1);
      check_val("idle_sum", sum, 32'd0);
    end

    directed(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 100; i++) begin
      drive_rand();
      in_valid = 1'b1;
      #1;
      check_val("stream_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    drain();

    exact_lat = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      in_valid = 1'b1;
      #1;
      if (!in_ready) break;
      acc++;
      step();
    end
    check_val("bp_fill_count", acc, 4);
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("bp_in_ready", in_ready, 1'b0);
      check_val("bp_out_valid", out_valid, 1'b1);
      check_val("bp_sum_hold", sum, mq[0].r[31:0]);
    end
    out_ready = 1'b1;
    #1;
    check_val("full_pass_ready", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      drive_rand();
      #1;
      check_val("full_out_valid", out_valid, 1'b1);
      check_val("full_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    drain();

    acc = 0;
    for (int i = 0; i < 20000 && acc < 1000; i++) begin
      drive_rand();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) acc++;
      step();
    end
    check_val("rand_accepts", acc, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check_val("no_loss_dup", n_ret, n_acc);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int m = 0; m < 4; m++) begin
          sw_a = corners[i]; sw_b = corners[j];
          sw_sub = 1'(m >> 1); sw_cin = 1'(m & 1);
          sw_valid = 1'b1;
          step();
        end
    for (int j = 0; j < 64; j++) begin
      sw_a = 64'd1 << j; sw_b = {64{1'b1}}; sw_cin = 1'b0; sw_sub = 1'(j & 1);
      sw_valid = 1'b1;
      step();
    end
    sw_valid = 1'b0;
    repeat (12) step();
    check_val("sweep_count", sw_acc, 3 * (256 + 64));
    check_val("sweep_drain", sw_ret, sw_acc);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    check_val("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_sum", sum, 32'd0);
    check_val("midrst_in_ready", in_ready, 1'b1);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("post_rst_idle", out_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
